lcd_lh507x_drv: RTL and testbench
=================================

LCD_LH507X_DRV -- requirements
Module: lcd_lh507x_drv

Interface
REQ-001 SHALL have parameter DATA_W, default 2, pixel data width per half-cycle.
REQ-002 SHALL have parameter WDOG_W, default 20, width of the vsync watchdog counter.
REQ-003 SHALL have parameter WDOG_LIMIT, default 20'd140448, clocks without a vsync edge before fault; SHALL be at most 2^WDOG_W-1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 disp_on  in  1  display enable request.
REQ-007 n_hsync, p_hsync, n_vsync, p_vsync, n_latch, p_latch, n_altsig, p_altsig, n_ctrl, p_ctrl, n_pclk, p_pclk  in  1 each  negative- and positive-half-cycle panel control values from the PPU.
REQ-008 n_px, p_px  in  DATA_W each  negative- and positive-half-cycle pixel data.
REQ-009 lcd_n_hsync, lcd_p_hsync, lcd_n_vsync, lcd_p_vsync, lcd_n_latch, lcd_p_latch, lcd_n_altsig, lcd_p_altsig, lcd_n_ctrl, lcd_p_ctrl, lcd_n_clk, lcd_p_clk  out  1 each  registered panel controls.
REQ-010 lcd_n_data, lcd_p_data  out  DATA_W each  registered panel data.
REQ-011 active  out  1  high in ACTIVE state.
REQ-012 wdog_trip  out  1  high in FAULT state.

Function
REQ-013 All lcd_* outputs SHALL be registers updated once per clk; latency input-to-output is exactly 1 cycle.
REQ-014 "Blank" SHALL mean every lcd_* output 0 on the next edge.
REQ-015 vs = n_vsync|p_vsync, hs = n_hsync|p_hsync; vs_edge / hs_edge SHALL be high when vs / hs is 1 and its registered value from the previous cycle is 0.
REQ-016 States: OFF, SYNC_WAIT, ACTIVE, DRAIN, FAULT; 3-bit encoding free.
REQ-017 OFF: outputs blanked; disp_on=1 -> SYNC_WAIT.
REQ-018 SYNC_WAIT: outputs blanked; disp_on=0 -> OFF (priority); else vs_edge -> ACTIVE, and that cycle's inputs SHALL be passed through so the first vsync reaches the panel.
REQ-019 ACTIVE: all inputs passed through; priority disp_on=0 -> DRAIN, else watchdog expiry -> FAULT.
REQ-020 DRAIN: controls passed through, lcd_n_data/lcd_p_data forced 0; hs_edge or watchdog expiry -> OFF, with that cycle's outputs blanked; disp_on returning to 1 SHALL NOT abort DRAIN.
REQ-021 FAULT: outputs blanked; disp_on=0 -> OFF; no other exit.
REQ-022 Watchdog counter (WDOG_W bits) SHALL clear to 0 on vs_edge, or in OFF/SYNC_WAIT/FAULT, else increment, saturating at WDOG_LIMIT.
REQ-023 Watchdog expiry SHALL be counter == WDOG_LIMIT and no vs_edge in the same cycle; vs_edge wins over expiry.
REQ-024 active and wdog_trip SHALL be registered, reflecting the current state with no extra latency beyond the state register.
REQ-025 Edge-detect registers SHALL update every cycle regardless of state.

Reset
REQ-026 reset=0 SHALL asynchronously force state OFF, watchdog 0, edge registers 0, all lcd_* outputs 0, active 0, wdog_trip 0.
REQ-027 On reset release, first possible state change SHALL be at the first rising clk edge with reset=1.
REQ-028 reset asserted mid-frame in any state SHALL blank outputs immediately, without waiting for a clk edge.

Verification
REQ-029 Reset, disp_on=1, n_vsync 0->1 at cycle 10 -> outputs 0 through cycle 10, lcd_n_vsync=1 at cycle 11, active=1 from cycle 11.
REQ-030 ACTIVE, n_px=2'b10, p_px=2'b01 at cycle N -> lcd_n_data=2'b10, lcd_p_data=2'b01 at N+1; all 14 outputs track inputs with 1-cycle delay.
REQ-031 ACTIVE, disp_on=0 at cycle N, p_hsync rises at N+5 -> data 0 from N+1, controls pass through to N+5, all outputs 0 from N+6, active=0 from N+1.
REQ-032 WDOG_LIMIT=100, ACTIVE, vsync held 0 after the edge -> wdog_trip=1 and outputs 0 after 100 cycles; disp_on=1 keeps FAULT; disp_on=0 -> OFF, wdog_trip=0.
REQ-033 WDOG_LIMIT=100, vs_edge exactly on the expiry cycle -> stays ACTIVE, counter 0, wdog_trip=0.
REQ-034 DATA_W=4, reset pulsed low mid-line in ACTIVE -> all outputs 0 before the next clk edge; after release, disp_on=1 and a vsync edge are required to reach ACTIVE again.

Source files
------------

// File: rtl/lcd_lh507x_drv.sv
`default_nettype none
// ============================================================================
// Module      : lcd_lh507x_drv
// Description : LH507x panel driver with power sequencing and vsync watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_lh507x_drv #(
    parameter int               DATA_W     = 2,
    parameter int               WDOG_W     = 20,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 20'd140448
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_on,
    input  logic              n_hsync,
    input  logic              p_hsync,
    input  logic              n_vsync,
    input  logic              p_vsync,
    input  logic              n_latch,
    input  logic              p_latch,
    input  logic              n_altsig,
    input  logic              p_altsig,
    input  logic              n_ctrl,
    input  logic              p_ctrl,
    input  logic              n_pclk,
    input  logic              p_pclk,
    input  logic [DATA_W-1:0] n_px,
    input  logic [DATA_W-1:0] p_px,
    output logic              lcd_n_hsync,
    output logic              lcd_p_hsync,
    output logic              lcd_n_vsync,
    output logic              lcd_p_vsync,
    output logic              lcd_n_latch,
    output logic              lcd_p_latch,
    output logic              lcd_n_altsig,
    output logic              lcd_p_altsig,
    output logic              lcd_n_ctrl,
    output logic              lcd_p_ctrl,
    output logic              lcd_n_clk,
    output logic              lcd_p_clk,
    output logic [DATA_W-1:0] lcd_n_data,
    output logic [DATA_W-1:0] lcd_p_data,
    output logic              active,
    output logic              wdog_trip
);

    localparam logic [2:0] c_st_off    = 3'd0;
    localparam logic [2:0] c_st_sync   = 3'd1;
    localparam logic [2:0] c_st_active = 3'd2;
    localparam logic [2:0] c_st_drain  = 3'd3;
    localparam logic [2:0] c_st_fault  = 3'd4;

    localparam logic [1:0] c_out_blank = 2'd0;
    localparam logic [1:0] c_out_pass  = 2'd1;
    localparam logic [1:0] c_out_drain = 2'd2;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [1:0]        w_mode;
    logic              r_vs_q;
    logic              r_hs_q;
    logic              w_vs;
    logic              w_hs;
    logic              w_vs_edge;
    logic              w_hs_edge;
    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              w_wdog_exp;
    logic              w_wdog_clr;
    logic [11:0]       w_ctl_in;
    logic [11:0]       r_ctl;
    logic [DATA_W-1:0] r_n_data;
    logic [DATA_W-1:0] r_p_data;
    logic              r_active;
    logic              r_wdog_trip;

    assign w_vs      = n_vsync | p_vsync;
    assign w_hs      = n_hsync | p_hsync;
    assign w_vs_edge = w_vs & ~r_vs_q;
    assign w_hs_edge = w_hs & ~r_hs_q;

    // A vsync edge arriving on the expiry cycle rescues the frame.
    assign w_wdog_exp = (r_wdog_cnt == WDOG_LIMIT) && !w_vs_edge;
    assign w_wdog_clr = w_vs_edge || (r_state == c_st_off) ||
                        (r_state == c_st_sync) || (r_state == c_st_fault);

    assign w_ctl_in = {n_hsync, p_hsync, n_vsync, p_vsync, n_latch, p_latch,
                       n_altsig, p_altsig, n_ctrl, p_ctrl, n_pclk, p_pclk};

    // Output mode is chosen from this cycle's transition so that the edge that
    // causes a state change already gets the new state's output treatment.
    always_comb begin
        w_state_nxt = r_state;
        w_mode      = c_out_blank;
        case (r_state)
            c_st_off: begin
                if (disp_on) w_state_nxt = c_st_sync;
            end
            c_st_sync: begin
                if (!disp_on) begin
                    w_state_nxt = c_st_off;
                end else if (w_vs_edge) begin
                    w_state_nxt = c_st_active;
                    w_mode      = c_out_pass;
                end
            end
            c_st_active: begin
                if (!disp_on) begin
                    w_state_nxt = c_st_drain;
                    w_mode      = c_out_drain;
                end else if (w_wdog_exp) begin
                    w_state_nxt = c_st_fault;
                end else begin
                    w_mode      = c_out_pass;
                end
            end
            c_st_drain: begin
                if (w_hs_edge || w_wdog_exp) begin
                    w_state_nxt = c_st_off;
                end else begin
                    w_mode      = c_out_drain;
                end
            end
            c_st_fault: begin
                if (!disp_on) w_state_nxt = c_st_off;
            end
            default: begin
                w_state_nxt = c_st_off;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_st_off;
            r_vs_q      <= 1'b0;
            r_hs_q      <= 1'b0;
            r_wdog_cnt  <= '0;
            r_ctl       <= '0;
            r_n_data    <= '0;
            r_p_data    <= '0;
            r_active    <= 1'b0;
            r_wdog_trip <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vs_q      <= w_vs;
            r_hs_q      <= w_hs;
            r_active    <= (w_state_nxt == c_st_active);
            r_wdog_trip <= (w_state_nxt == c_st_fault);

            if (w_wdog_clr) begin
                r_wdog_cnt <= '0;
            end else if (r_wdog_cnt != WDOG_LIMIT) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end

            r_ctl    <= (w_mode == c_out_blank) ? 12'd0 : w_ctl_in;
            r_n_data <= (w_mode == c_out_pass) ? n_px : '0;
            r_p_data <= (w_mode == c_out_pass) ? p_px : '0;
        end
    end

    assign {lcd_n_hsync, lcd_p_hsync, lcd_n_vsync, lcd_p_vsync,
            lcd_n_latch, lcd_p_latch, lcd_n_altsig, lcd_p_altsig,
            lcd_n_ctrl, lcd_p_ctrl, lcd_n_clk, lcd_p_clk} = r_ctl;
    assign lcd_n_data = r_n_data;
    assign lcd_p_data = r_p_data;
    assign active     = r_active;
    assign wdog_trip  = r_wdog_trip;

endmodule
`default_nettype wire

// File: tb/tb_lcd_lh507x_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_lh507x_drv
// Description : Self-checking bench for lcd_lh507x_drv (scoreboard + scenarios).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_lh507x_drv;

    localparam int DW    = 4;
    localparam int LIMIT = 100;
    localparam int OW    = 12 + 2 * DW + 2;

    localparam int S_OFF = 0, S_SYNC = 1, S_ACT = 2, S_DRAIN = 3, S_FAULT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          disp_on = 1'b0;
    logic [11:0]   ctl = '0;   // {n_hs,p_hs,n_vs,p_vs,n_lat,p_lat,n_alt,p_alt,n_ctl,p_ctl,n_pclk,p_pclk}
    logic [DW-1:0] npx = '0;
    logic [DW-1:0] ppx = '0;

    logic          lcd_n_hsync, lcd_p_hsync, lcd_n_vsync, lcd_p_vsync;
    logic          lcd_n_latch, lcd_p_latch, lcd_n_altsig, lcd_p_altsig;
    logic          lcd_n_ctrl, lcd_p_ctrl, lcd_n_clk, lcd_p_clk;
    logic [DW-1:0] lcd_n_data, lcd_p_data;
    logic          active, wdog_trip;
    logic [OW-1:0] obs;

    int errors = 0;
    int checks = 0;

    logic [OW-1:0] sb[$];

    int m_state = S_OFF;
    int m_cnt   = 0;
    logic m_vsq = 1'b0;
    logic m_hsq = 1'b0;

    lcd_lh507x_drv #(
        .DATA_W    (DW),
        .WDOG_W    (20),
        .WDOG_LIMIT(20'd100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_on     (disp_on),
        .n_hsync     (ctl[11]),
        .p_hsync     (ctl[10]),
        .n_vsync     (ctl[9]),
        .p_vsync     (ctl[8]),
        .n_latch     (ctl[7]),
        .p_latch     (ctl[6]),
        .n_altsig    (ctl[5]),
        .p_altsig    (ctl[4]),
        .n_ctrl      (ctl[3]),
        .p_ctrl      (ctl[2]),
        .n_pclk      (ctl[1]),
        .p_pclk      (ctl[0]),
        .n_px        (npx),
        .p_px        (ppx),
        .lcd_n_hsync (lcd_n_hsync),
        .lcd_p_hsync (lcd_p_hsync),
        .lcd_n_vsync (lcd_n_vsync),
        .lcd_p_vsync (lcd_p_vsync),
        .lcd_n_latch (lcd_n_latch),
        .lcd_p_latch (lcd_p_latch),
        .lcd_n_altsig(lcd_n_altsig),
        .lcd_p_altsig(lcd_p_altsig),
        .lcd_n_ctrl  (lcd_n_ctrl),
        .lcd_p_ctrl  (lcd_p_ctrl),
        .lcd_n_clk   (lcd_n_clk),
        .lcd_p_clk   (lcd_p_clk),
        .lcd_n_data  (lcd_n_data),
        .lcd_p_data  (lcd_p_data),
        .active      (active),
        .wdog_trip   (wdog_trip)
    );

    assign obs = {lcd_n_hsync, lcd_p_hsync, lcd_n_vsync, lcd_p_vsync,
                  lcd_n_latch, lcd_p_latch, lcd_n_altsig, lcd_p_altsig,
                  lcd_n_ctrl, lcd_p_ctrl, lcd_n_clk, lcd_p_clk,
                  lcd_n_data, lcd_p_data, active, wdog_trip};

    always #5 clk = ~clk;

    // Monitor: every clocked cycle produces exactly one expected output word.
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            logic [OW-1:0] e;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, obs, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Reference model: predicts outputs for this cycle's inputs, then clocks once.
    task automatic tick();
        logic vs, hs, vse, hse, wexp;
        int nxt, mode, ncnt;
        logic [OW-1:0] e;
        vs   = ctl[9] | ctl[8];
        hs   = ctl[11] | ctl[10];
        vse  = vs && !m_vsq;
        hse  = hs && !m_hsq;
        wexp = (m_cnt == LIMIT) && !vse;
        nxt  = m_state;
        mode = 0;  // 0 blank, 1 pass, 2 controls only
        case (m_state)
            S_OFF:   nxt = disp_on ? S_SYNC : S_OFF;
            S_SYNC:  if (!disp_on) nxt = S_OFF;
                     else if (vse) begin nxt = S_ACT; mode = 1; end
            S_ACT:   if (!disp_on) begin nxt = S_DRAIN; mode = 2; end
                     else if (wexp) nxt = S_FAULT;
                     else mode = 1;
            S_DRAIN: if (hse || wexp) nxt = S_OFF;
                     else mode = 2;
            default: nxt = disp_on ? S_FAULT : S_OFF;
        endcase
        if (vse || m_state == S_OFF || m_state == S_SYNC || m_state == S_FAULT) ncnt = 0;
        else if (m_cnt == LIMIT) ncnt = m_cnt;
        else ncnt = m_cnt + 1;
        e = {(mode == 0) ? 12'd0 : ctl,
             (mode == 1) ? npx : {DW{1'b0}},
             (mode == 1) ? ppx : {DW{1'b0}},
             (nxt == S_ACT), (nxt == S_FAULT)};
        sb.push_back(e);
        @(posedge clk);
        #1;
        m_state = nxt;
        m_cnt   = ncnt;
        m_vsq   = vs;
        m_hsq   = hs;
    endtask

    task automatic model_reset();
        sb.delete();
        m_state = S_OFF;
        m_cnt   = 0;
        m_vsq   = 1'b0;
        m_hsq   = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        disp_on = 1'b1;
        ctl     = 12'hFFF;
        npx     = '1;
        ppx     = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0", obs);
        end
        #2 reset = 1'b1;
        disp_on = 1'b0;
        ctl = '0;
        npx = '0;
        ppx = '0;
    endtask

    task automatic test_startup();
        disp_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ctl = 12'($urandom) & 12'hCFF;
            tick();
        end
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL startup_blank got=%h expected=0", obs);
        end
        ctl = 12'h200;
        npx = 4'h6;
        tick();
        checks++;
        if (lcd_n_vsync !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL startup_first_vsync got vs=%b active=%b expected vs=1 active=1",
                     lcd_n_vsync, active);
        end
    endtask

    task automatic test_passthrough();
        ctl = 12'h0A5;
        npx = 4'b0010;
        ppx = 4'b0001;
        tick();
        checks++;
        if (lcd_n_data !== 4'b0010 || lcd_p_data !== 4'b0001 || obs[OW-1:OW-12] !== 12'h0A5) begin
            errors++;
            $display("FAIL passthrough got n=%h p=%h ctl=%h expected n=2 p=1 ctl=0a5",
                     lcd_n_data, lcd_p_data, obs[OW-1:OW-12]);
        end
        for (int i = 0; i < 20; i++) begin
            ctl = 12'($urandom);
            npx = DW'($urandom);
            ppx = DW'($urandom);
            tick();
        end
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL passthrough_active got=%b expected=1", active);
        end
    endtask

    task automatic test_drain();
        ctl = 12'h055;
        tick();
        disp_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ctl = (12'($urandom) & 12'h0FF);
            npx = 4'hF;
            ppx = 4'hF;
            tick();
            checks++;
            if (active !== 1'b0 || lcd_n_data !== '0 || lcd_p_data !== '0 ||
                obs[OW-1:OW-12] !== ctl) begin
                errors++;
                $display("FAIL drain_cycle%0d got ctl=%h n=%h p=%h act=%b expected ctl=%h data=0 act=0",
                         i, obs[OW-1:OW-12], lcd_n_data, lcd_p_data, active, ctl);
            end
            if (i == 2) disp_on = 1'b1;  // must not abort drain
        end
        ctl = 12'h4FF;
        tick();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL drain_hsync_blank got=%h expected=0", obs);
        end
        disp_on = 1'b0;
        ctl = 12'h0;
        tick();
    endtask

    task automatic test_watchdog();
        disp_on = 1'b1;
        ctl = 12'h000;
        tick();
        tick();
        ctl = 12'h100;
        tick();
        ctl = 12'h0F3;
        repeat (LIMIT) tick();
        checks++;
        if (active !== 1'b1 || wdog_trip !== 1'b0) begin
            errors++;
            $display("FAIL wdog_before_limit got act=%b trip=%b expected act=1 trip=0", active, wdog_trip);
        end
        tick();
        checks++;
        if (obs !== {{(OW-1){1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL wdog_trip got=%h expected=%h", obs, {{(OW-1){1'b0}}, 1'b1});
        end
        for (int i = 0; i < 5; i++) begin
            ctl = 12'($urandom);
            tick();
        end
        checks++;
        if (wdog_trip !== 1'b1 || obs[OW-1:2] !== '0) begin
            errors++;
            $display("FAIL wdog_hold got=%h expected trip only", obs);
        end
        disp_on = 1'b0;
        tick();
        checks++;
        if (wdog_trip !== 1'b0) begin
            errors++;
            $display("FAIL wdog_clear got=%b expected=0", wdog_trip);
        end
        ctl = 12'h000;
        tick();
    endtask

    task automatic test_vs_on_expiry();
        disp_on = 1'b1;
        ctl = 12'h000;
        tick();
        ctl = 12'h200;
        tick();
        ctl = 12'h000;
        repeat (LIMIT) tick();
        ctl = 12'h100;
        tick();
        checks++;
        if (active !== 1'b1 || wdog_trip !== 1'b0) begin
            errors++;
            $display("FAIL vs_on_expiry got act=%b trip=%b expected act=1 trip=0", active, wdog_trip);
        end
        ctl = 12'h000;
        repeat (LIMIT) tick();
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL vs_on_expiry_restart got act=%b expected=1", active);
        end
        tick();
        checks++;
        if (wdog_trip !== 1'b1) begin
            errors++;
            $display("FAIL vs_on_expiry_retrip got trip=%b expected=1", wdog_trip);
        end
        disp_on = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        disp_on = 1'b1;
        ctl = 12'h000;
        tick();
        tick();
        ctl = 12'hFFF;
        npx = 4'hA;
        ppx = 4'h5;
        tick();
        tick();
        checks++;
        if (lcd_n_data !== 4'hA || active !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got n=%h act=%b expected n=a act=1", lcd_n_data, active);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_blank got=%h expected=0", obs);
        end
        model_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        ctl = 12'h0F0;
        repeat (5) tick();
        checks++;
        if (active !== 1'b0 || obs !== '0) begin
            errors++;
            $display("FAIL async_need_vsync got=%h expected=0", obs);
        end
        ctl = 12'h2F0;
        tick();
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL async_reacquire got act=%b expected=1", active);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) disp_on = ~disp_on;
            ctl = 12'($urandom);
            if ($urandom_range(0, 59) != 0) ctl[9:8] = 2'b00;
            if ($urandom_range(0, 7) != 0) ctl[11:10] = 2'b00;
            npx = DW'($urandom);
            ppx = DW'($urandom);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_passthrough();
        test_drain();
        test_watchdog();
        test_vs_on_expiry();
        test_async_reset();
        test_back_to_back();
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
